// File: rtl/aludec_seq.sv
// Registered, handshaked ALU opcode decoder with multi-cycle MUL/DIV stall
// and a saturating count of accepted illegal opcodes.
module aludec_seq #(
  parameter int unsigned OPW  = 4,
  parameter int unsigned ALUW = 3,
  parameter int unsigned MCYC = 4,
  parameter int unsigned ERRW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [OPW-1:0]  in_opcode,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ALUW-1:0] out_aluop,
  output logic            out_illegal,
  output logic            out_multi,
  output logic            busy,
  output logic [ERRW-1:0] err_count
);

  localparam int unsigned CNTW = (MCYC > 1) ? $clog2(MCYC) : 1;

  typedef enum logic [1:0] {IDLE, MULTI, FULL} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_cnt_nxt;
  logic [2:0]      r_aluop;
  logic            r_illegal;
  logic            r_multi;
  logic [ERRW-1:0] r_err;
  logic            w_in_xfer;
  logic            w_out_xfer;
  logic [2:0]      w_dec_op;
  logic            w_dec_ill;
  logic            w_dec_mul;

  // Opcode decode; unknown or out-of-range opcodes fall through to illegal.
  always_comb begin
    w_dec_op  = 3'b000;
    w_dec_ill = 1'b0;
    w_dec_mul = 1'b0;
    if (in_opcode < OPW'(8)) begin
      w_dec_op = in_opcode[2:0];
    end else if (in_opcode < OPW'(10)) begin
      w_dec_op  = {2'b00, in_opcode[0]};
      w_dec_mul = 1'b1;
    end else begin
      w_dec_ill = 1'b1;
    end
  end

  // Handshake and next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    in_ready    = 1'b0;
    case (r_state)
      IDLE:    in_ready = 1'b1;
      FULL:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    if (rst) in_ready = 1'b0;
    w_in_xfer  = in_valid && in_ready;
    w_out_xfer = (r_state == FULL) && out_ready;
    case (r_state)
      MULTI: begin
        if (r_cnt == CNTW'(1)) begin
          w_state_nxt = FULL;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNTW'(1);
        end
      end
      FULL:    if (w_out_xfer) w_state_nxt = IDLE;
      default: ;
    endcase
    // A new accept overrides the drain decision, giving back-to-back issue.
    if (w_in_xfer) begin
      if (w_dec_mul && (MCYC > 1)) begin
        w_state_nxt = MULTI;
        w_cnt_nxt   = CNTW'(MCYC - 1);
      end else begin
        w_state_nxt = FULL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_aluop   <= 3'b000;
      r_illegal <= 1'b0;
      r_multi   <= 1'b0;
      r_err     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_in_xfer) begin
        r_aluop   <= w_dec_op;
        r_illegal <= w_dec_ill;
        r_multi   <= w_dec_mul;
        if (w_dec_ill && (r_err != '1)) r_err <= r_err + ERRW'(1);
      end
    end
  end

  assign out_valid   = (r_state == FULL);
  assign busy        = (r_state == MULTI);
  assign out_aluop   = ALUW'(r_aluop);
  assign out_illegal = r_illegal;
  assign out_multi   = r_multi;
  assign err_count   = r_err;

endmodule

// File: tb/tb_aludec_seq.sv
// Bench for aludec_seq: a MCYC=4 and a MCYC=1 instance share stimulus and are
// each checked every cycle against a transaction-level model.
module tb_aludec_seq;

  localparam int MC [2] = '{4, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_opcode;
  logic       out_ready;

  logic       d_rdy  [2];
  logic       d_vld  [2];
  logic [2:0] d_aop  [2];
  logic       d_ill  [2];
  logic       d_mul  [2];
  logic       d_busy [2];
  logic [7:0] d_err  [2];

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aludec_seq #(.OPW(4), .ALUW(3), .MCYC(4), .ERRW(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_ready(d_rdy[0]), .out_valid(d_vld[0]), .out_ready(out_ready),
    .out_aluop(d_aop[0]), .out_illegal(d_ill[0]), .out_multi(d_mul[0]),
    .busy(d_busy[0]), .err_count(d_err[0])
  );

  aludec_seq #(.OPW(4), .ALUW(3), .MCYC(1), .ERRW(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_ready(d_rdy[1]), .out_valid(d_vld[1]), .out_ready(out_ready),
    .out_aluop(d_aop[1]), .out_illegal(d_ill[1]), .out_multi(d_mul[1]),
    .busy(d_busy[1]), .err_count(d_err[1])
  );

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut%0d) at %0t: got %0h, expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Model: a pending result becomes visible at cycle m_avail; cyc counts edges.
  int  cyc = 0;
  bit  m_live = 1'b0;
  bit  m_pend  [2] = '{1'b0, 1'b0};
  int  m_avail [2] = '{0, 0};
  int  m_op    [2] = '{0, 0};
  bit  m_ill   [2] = '{1'b0, 1'b0};
  bit  m_mul   [2] = '{1'b0, 1'b0};
  int  m_err   [2] = '{0, 0};
  bit  m_clean [2] = '{1'b1, 1'b1};
  bit  busy1_seen = 1'b0;

  function automatic bit ev(int k);
    return m_pend[k] && (cyc >= m_avail[k]);
  endfunction
  function automatic bit eb(int k);
    return m_pend[k] && (cyc < m_avail[k]);
  endfunction
  function automatic bit er(int k);
    return !rst && (!m_pend[k] || (ev(k) && out_ready));
  endfunction

  always @(posedge clk) begin : model
    bit acc;
    bit oxf;
    int op;
    for (int k = 0; k < 2; k++) begin
      acc = in_valid && er(k);
      oxf = ev(k) && out_ready;
      if (rst) begin
        m_pend[k]  = 1'b0;
        m_op[k]    = 0;
        m_ill[k]   = 1'b0;
        m_mul[k]   = 1'b0;
        m_err[k]   = 0;
        m_clean[k] = 1'b1;
      end else begin
        if (oxf) m_pend[k] = 1'b0;
        if (acc) begin
          op         = int'(in_opcode);
          m_clean[k] = 1'b0;
          m_pend[k]  = 1'b1;
          m_ill[k]   = (op >= 10);
          m_mul[k]   = (op == 8) || (op == 9);
          m_op[k]    = (op < 8) ? op : ((op < 10) ? op - 8 : 0);
          m_avail[k] = cyc + (m_mul[k] ? MC[k] : 1);
          if (m_ill[k] && (m_err[k] < 255)) m_err[k]++;
        end
      end
    end
    if (rst) m_live = 1'b1;
    cyc++;
  end

  always @(negedge clk) begin
    if (m_live) begin
      for (int k = 0; k < 2; k++) begin
        chk("in_ready", k, 32'(d_rdy[k]), 32'(er(k)));
        chk("out_valid", k, 32'(d_vld[k]), 32'(ev(k)));
        chk("busy", k, 32'(d_busy[k]), 32'(eb(k)));
        chk("err_count", k, 32'(d_err[k]), 32'(m_err[k]));
        if (ev(k) || m_clean[k]) begin
          chk("out_aluop", k, 32'(d_aop[k]), 32'(m_op[k]));
          chk("out_illegal", k, 32'(d_ill[k]), 32'(m_ill[k]));
          chk("out_multi", k, 32'(d_mul[k]), 32'(m_mul[k]));
        end
      end
      if (d_busy[1] === 1'b1) busy1_seen = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept a MUL/DIV on dut0 and pin its stall length and result literally.
  task automatic run_multi(input logic [3:0] op, input logic [2:0] exp_aop);
    in_valid  = 1'b1;
    in_opcode = op;
    step();
    in_valid = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      chk("mc busy", 0, 32'(d_busy[0]), 32'd1);
      chk("mc in_ready", 0, 32'(d_rdy[0]), 32'd0);
      chk("mc early valid", 0, 32'(d_vld[0]), 32'd0);
      if (j == 1) begin
        chk("mc1 valid", 1, 32'(d_vld[1]), 32'd1);
        chk("mc1 multi", 1, 32'(d_mul[1]), 32'd1);
        chk("mc1 aluop", 1, 32'(d_aop[1]), 32'(exp_aop));
        chk("mc1 busy", 1, 32'(d_busy[1]), 32'd0);
      end
    end
    @(negedge clk);
    chk("mc valid", 0, 32'(d_vld[0]), 32'd1);
    chk("mc aluop", 0, 32'(d_aop[0]), 32'(exp_aop));
    chk("mc multi", 0, 32'(d_mul[0]), 32'd1);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_opcode = 4'd0;
    out_ready = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst in_ready", 0, 32'(d_rdy[0]), 32'd1);
    chk("rst out_valid", 0, 32'(d_vld[0]), 32'd0);
    chk("rst aluop", 0, 32'(d_aop[0]), 32'd0);
    chk("rst err", 0, 32'(d_err[0]), 32'd0);
    #1;

    // Single-cycle ops, one per cycle.
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      in_opcode = 4'(i);
      step();
      @(negedge clk);
      chk("t1 valid", 0, 32'(d_vld[0]), 32'd1);
      chk("t1 aluop", 0, 32'(d_aop[0]), 32'(i));
      chk("t1 illegal", 0, 32'(d_ill[0]), 32'd0);
      chk("t1 multi", 0, 32'(d_mul[0]), 32'd0);
      chk("t1 err", 0, 32'(d_err[0]), 32'd0);
      #1;
    end
    in_valid = 1'b0;

    run_multi(4'd8, 3'b000);
    run_multi(4'd9, 3'b001);

    // Illegal opcodes and counter saturation.
    for (int i = 10; i < 16; i++) begin
      in_valid  = 1'b1;
      in_opcode = 4'(i);
      step();
      @(negedge clk);
      chk("t3 illegal", 0, 32'(d_ill[0]), 32'd1);
      chk("t3 aluop", 0, 32'(d_aop[0]), 32'd0);
      chk("t3 err", 0, 32'(d_err[0]), 32'(i - 9));
      #1;
    end
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'b1;
      in_opcode = 4'($urandom_range(10, 15));
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3 saturate", 0, 32'(d_err[0]), 32'd255);
    chk("t3 saturate", 1, 32'(d_err[1]), 32'd255);
    #1;

    // Backpressure with a waiting producer.
    step(); step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_opcode = 4'd3;
    step();
    in_opcode = 4'd4;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("t4 held valid", 0, 32'(d_vld[0]), 32'd1);
      chk("t4 held aluop", 0, 32'(d_aop[0]), 32'd3);
      chk("t4 in_ready", 0, 32'(d_rdy[0]), 32'd0);
    end
    #1;
    out_ready = 1'b1;
    #1;
    chk("t4 release ready", 0, 32'(d_rdy[0]), 32'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4 new valid", 0, 32'(d_vld[0]), 32'd1);
    chk("t4 new aluop", 0, 32'(d_aop[0]), 32'd4);
    #1;

    // Reset in the middle of a MUL stall.
    in_valid  = 1'b1;
    in_opcode = 4'd8;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("t5 ready in rst", 0, 32'(d_rdy[0]), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5 valid", 0, 32'(d_vld[0]), 32'd0);
    chk("t5 aluop", 0, 32'(d_aop[0]), 32'd0);
    chk("t5 illegal", 0, 32'(d_ill[0]), 32'd0);
    chk("t5 multi", 0, 32'(d_mul[0]), 32'd0);
    chk("t5 busy", 0, 32'(d_busy[0]), 32'd0);
    chk("t5 err", 0, 32'(d_err[0]), 32'd0);
    chk("t5 in_ready", 0, 32'(d_rdy[0]), 32'd1);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("t5 no pulse", 0, 32'(d_vld[0]), 32'd0);
    end
    #1;

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_opcode = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 99) < 70);
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step(); step();

    @(negedge clk);
    chk("mcyc1 busy never", 1, 32'(busy1_seen), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
